// File: rtl/rs232_frame_tx.sv
// Buffered RS232 frame transmitter: valid/ready word FIFO feeding a
// start/data/parity/stop serialiser gated by CTS at each frame start.
module rs232_frame_tx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 2,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_BITS-1:0]         data_in,
    input  logic                         data_valid,
    output logic                         data_ready,
    input  logic                         cts,
    output logic                         tx,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         overflow
);

    localparam int BIT_TICKS = CLK_FREQ / BAUD;
    localparam int TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        next_count;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic [TW-1:0]        tick;
    logic [3:0]           bit_cnt;
    logic                 push;
    logic                 pop;
    logic                 tick_wrap;
    logic                 stop_last;
    logic [DATA_BITS-1:0] head;

    assign push      = data_valid && data_ready;
    assign tick_wrap = (tick == TW'(BIT_TICKS - 1));
    assign stop_last = (state == STOP) && tick_wrap
                       && (bit_cnt == 4'(STOP_BITS - 1));
    // A new frame may only begin from IDLE or on the final STOP tick.
    assign pop       = (fifo_count != '0) && cts
                       && ((state == IDLE) || stop_last);
    assign head      = mem[rd_ptr];

    always_comb begin
        next_count = fifo_count;
        unique case ({push, pop})
            2'b10:   next_count = fifo_count + 1'b1;
            2'b01:   next_count = fifo_count - 1'b1;
            default: next_count = fifo_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push && !rst)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            data_ready <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= next_count;
            data_ready <= (next_count != CW'(FIFO_DEPTH));
            if (data_valid && !data_ready)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            tick    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        state   <= START;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                        tick    <= '0;
                        bit_cnt <= '0;
                        shreg   <= head;
                        par_bit <= (^head) ^ (PARITY == 1);
                    end
                end
                START: begin
                    if (tick_wrap) begin
                        tick  <= '0;
                        state <= DATA;
                        tx    <= shreg[0];
                        shreg <= shreg >> 1;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_wrap) begin
                        tick <= '0;
                        if (bit_cnt == 4'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            if (PARITY != 0) begin
                                state <= PAR;
                                tx    <= par_bit;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                PAR: begin
                    if (tick_wrap) begin
                        tick  <= '0;
                        state <= STOP;
                        tx    <= 1'b1;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_wrap) begin
                        tick <= '0;
                        if (stop_last) begin
                            bit_cnt <= '0;
                            if (pop) begin
                                state   <= START;
                                tx      <= 1'b0;
                                shreg   <= head;
                                par_bit <= (^head) ^ (PARITY == 1);
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs232_frame_tx.sv
// Directed bench for rs232_frame_tx: three parameter sets, frames decoded
// mid-bit on the line and compared against a queue of modelled frames.
`timescale 1ns/1ps
module tb_rs232_frame_tx;

    localparam int BT = 10;

    typedef struct {
        logic [15:0] bits;
        int          n;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] din;
    logic       vld;
    logic       cts;
    int         sel;

    logic       v0, v1, v2;
    logic       rdy0, rdy1, rdy2;
    logic       tx0, tx1, tx2;
    logic       bsy0, bsy1, bsy2;
    logic [4:0] cnt0, cnt1, cnt2;
    logic       ovf0, ovf1, ovf2;
    logic       tx_s, busy_s;

    int total = 0;
    int bad   = 0;
    frame_t sbq[$];
    int DB[3] = '{8, 8, 7};
    int PB[3] = '{2, 1, 0};
    int SB[3] = '{1, 1, 2};

    always #5 clk = ~clk;

    assign v0 = vld && (sel == 0);
    assign v1 = vld && (sel == 1);
    assign v2 = vld && (sel == 2);
    assign tx_s   = (sel == 0) ? tx0  : (sel == 1) ? tx1  : tx2;
    assign busy_s = (sel == 0) ? bsy0 : (sel == 1) ? bsy1 : bsy2;

    rs232_frame_tx #(.CLK_FREQ(1000), .BAUD(100)) u_even (
        .clk(clk), .rst(rst), .data_in(din[7:0]), .data_valid(v0),
        .data_ready(rdy0), .cts(cts), .tx(tx0), .busy(bsy0),
        .fifo_count(cnt0), .overflow(ovf0));

    rs232_frame_tx #(.CLK_FREQ(1000), .BAUD(100), .PARITY(1)) u_odd (
        .clk(clk), .rst(rst), .data_in(din[7:0]), .data_valid(v1),
        .data_ready(rdy1), .cts(cts), .tx(tx1), .busy(bsy1),
        .fifo_count(cnt1), .overflow(ovf1));

    rs232_frame_tx #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(7),
                     .PARITY(0), .STOP_BITS(2)) u_d7 (
        .clk(clk), .rst(rst), .data_in(din[6:0]), .data_valid(v2),
        .data_ready(rdy2), .cts(cts), .tx(tx2), .busy(bsy2),
        .fifo_count(cnt2), .overflow(ovf2));

    function automatic frame_t mk(input logic [8:0] w, input int s);
        frame_t f;
        int     k;
        logic   p;
        f.bits = '0;
        k = 1;
        p = 1'b0;
        for (int i = 0; i < DB[s]; i++) begin
            f.bits[k] = w[i];
            p = p ^ w[i];
            k++;
        end
        if (PB[s] != 0) begin
            f.bits[k] = (PB[s] == 1) ? ~p : p;
            k++;
        end
        for (int i = 0; i < SB[s]; i++) begin
            f.bits[k] = 1'b1;
            k++;
        end
        f.n = k;
        return f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [8:0] w, input bit acc);
        @(negedge clk);
        din = w;
        vld = 1'b1;
        if (acc)
            sbq.push_back(mk(w, sel));
        @(negedge clk);
        vld = 1'b0;
    endtask

    // aligned: caller already sits on the first negedge of the start bit.
    task automatic check_frame(input bit aligned, input bit b2b);
        frame_t f;
        bit     found;
        chk("sb_nonempty", 32'(sbq.size() != 0), 1);
        if (sbq.size() == 0)
            return;
        f = sbq.pop_front();
        if (!aligned) begin
            found = 1'b0;
            for (int i = 0; i < 2000 && !found; i++) begin
                @(negedge clk);
                if (tx_s === 1'b0)
                    found = 1'b1;
            end
            chk("start_seen", 32'(found), 1);
            if (!found)
                return;
        end
        repeat (BT / 2) @(negedge clk);
        for (int k = 0; k < f.n; k++) begin
            chk($sformatf("s%0d_bit%0d", sel, k), 32'(tx_s), 32'(f.bits[k]));
            if (k < f.n - 1)
                repeat (BT) @(negedge clk);
        end
        repeat (BT - BT / 2 - 1) @(negedge clk);
        chk("busy_last", 32'(busy_s), 1);
        @(negedge clk);
        if (b2b) begin
            chk("b2b_start", 32'(tx_s), 0);
            chk("b2b_busy", 32'(busy_s), 1);
        end else begin
            chk("end_busy", 32'(busy_s), 0);
            chk("end_tx", 32'(tx_s), 1);
        end
    endtask

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        rst = 1'b1;
        vld = 1'b0;
        cts = 1'b0;
        din = '0;
        sel = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(rdy0), 0);
        chk("rst_tx", 32'(tx0), 1);
        chk("rst_busy", 32'(bsy0), 0);
        chk("rst_count", 32'(cnt0), 0);
        chk("rst_ovf", 32'(ovf0), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(rdy0), 1);

        // even parity, one-clock latency from write to start bit
        cts = 1'b1;
        push(9'h053, 1'b1);
        chk("lat_tx_hi", 32'(tx_s), 1);
        @(negedge clk);
        chk("lat_tx_lo", 32'(tx_s), 0);
        chk("lat_busy", 32'(busy_s), 1);
        check_frame(1'b1, 1'b0);

        sel = 1;
        push(9'h053, 1'b1);
        check_frame(1'b0, 1'b0);

        sel = 2;
        push(9'h041, 1'b1);
        check_frame(1'b0, 1'b0);

        // cts dropped mid-frame: frame completes, next waits for cts
        sel = 0;
        cts = 1'b0;
        push(9'h0c5, 1'b1);
        push(9'h03a, 1'b1);
        @(negedge clk);
        cts = 1'b1;
        fork
            check_frame(1'b0, 1'b0);
            begin
                repeat (45) @(negedge clk);
                cts = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        chk("cts_hold_tx", 32'(tx_s), 1);
        chk("cts_hold_cnt", 32'(cnt0), 1);
        chk("cts_no_ovf", 32'(ovf0), 0);
        cts = 1'b1;
        @(negedge clk);
        chk("cts_resume", 32'(tx_s), 0);
        check_frame(1'b1, 1'b0);

        // fill to full, overflow, then 16 back-to-back frames
        cts = 1'b0;
        for (int i = 0; i < 15; i++)
            push(9'($urandom_range(0, 255)), 1'b1);
        chk("ready_15", 32'(rdy0), 1);
        push(9'($urandom_range(0, 255)), 1'b1);
        chk("full_ready", 32'(rdy0), 0);
        chk("full_count", 32'(cnt0), 16);
        push(9'h0aa, 1'b0);
        chk("ovf_set", 32'(ovf0), 1);
        chk("ovf_count", 32'(cnt0), 16);
        @(negedge clk);
        cts = 1'b1;
        check_frame(1'b0, 1'b1);
        for (int i = 0; i < 14; i++)
            check_frame(1'b1, 1'b1);
        check_frame(1'b1, 1'b0);
        chk("ovf_sticky", 32'(ovf0), 1);
        chk("drained", 32'(cnt0), 0);

        // reset during data bit 4 with three words still queued
        cts = 1'b0;
        for (int i = 0; i < 4; i++)
            push(9'(8'h11 * (i + 1)), 1'b1);
        @(negedge clk);
        cts = 1'b1;
        @(negedge clk);
        chk("r5_start", 32'(tx_s), 0);
        repeat (52) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("r5_tx", 32'(tx0), 1);
        chk("r5_busy", 32'(bsy0), 0);
        chk("r5_count", 32'(cnt0), 0);
        chk("r5_ovf", 32'(ovf0), 0);
        chk("r5_ready", 32'(rdy0), 0);
        rst = 1'b0;
        sbq.delete();
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx_s !== 1'b1)
                lows++;
        end
        chk("r5_no_frames", 32'(lows), 0);
        chk("r5_idle_busy", 32'(bsy0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
